// File: rtl/hit_db_feeder_if.sv
// rtl/hit_db_feeder_if.sv - control, DDR read and detector signal bundle for hit_db_feeder
// Purpose: groups every non-clock/reset signal of the feeder.
//   master : the feeder side (drives requests, detector controls, status)
//   slave  : the environment side (DDR, detector, extender, host)
// Ports (all in the bundle):
//   start/db_base_addr/db_num_words    scan command
//   busy/done/hit_count                scan status
//   rd_req_*/rd_data*                  1-outstanding DDR read port
//   dataBase/dataBaseValid/load/shift  detector feed
//   stop/locationStart/locationEnd     hit handoff
//   hit/ext_done                       detector hit and extender completion
interface hit_db_feeder_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] db_base_addr;
  logic [31:0]       db_num_words;
  logic              busy;
  logic              done;
  logic [31:0]       hit_count;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              rd_data_ready;

  logic [DATA_W-1:0] dataBase;
  logic              dataBaseValid;
  logic              load;
  logic              shift;
  logic              stop;
  logic [31:0]       locationStart;
  logic [31:0]       locationEnd;
  logic              hit;
  logic              ext_done;

  modport master (
    input  start, db_base_addr, db_num_words, rd_req_ready, rd_data, rd_data_valid, hit, ext_done,
    output busy, done, hit_count, rd_req_valid, rd_req_addr, rd_data_ready,
           dataBase, dataBaseValid, load, shift, stop, locationStart, locationEnd
  );

  modport slave (
    output start, db_base_addr, db_num_words, rd_req_ready, rd_data, rd_data_valid, hit, ext_done,
    input  busy, done, hit_count, rd_req_valid, rd_req_addr, rd_data_ready,
           dataBase, dataBaseValid, load, shift, stop, locationStart, locationEnd
  );
endinterface

// File: rtl/hit_db_feeder.sv
// rtl/hit_db_feeder.sv - database-side driver for the w-mer hit detector
// Purpose: fetches db_num_words words from DDR (one request outstanding, one-word
//   prefetch buffer), feeds each word to the detector one nucleotide per cycle,
//   pauses on every hit until the extender reports ext_done, then resumes.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       hit_db_feeder_if.master (command/status, DDR read port, detector feed)
module hit_db_feeder #(
  parameter int DATA_W  = 512,
  parameter int WMER_NT = 11,
  parameter int ADDR_W  = 32
) (
  input logic             clk,
  input logic             rst,
  hit_db_feeder_if.master bus
);
  localparam logic [31:0]       NT_PER_WORD = 32'(DATA_W / 2);
  localparam logic [7:0]        LAST_POS    = 8'(DATA_W / 2 - WMER_NT);
  localparam logic [ADDR_W-1:0] STRIDE      = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_WAITW, S_LOAD, S_SCAN, S_HOLD, S_STOP, S_NEXT, S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       num_q;
  logic [31:0]       req_idx_q;
  logic [31:0]       cur_idx_q;
  logic [7:0]        pos_q;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full_q;
  logic              outstanding_q;
  logic [DATA_W-1:0] data_base_q;
  logic              dbv_q;
  logic              load_q;
  logic              stop_q;
  logic              done_q;
  logic              busy_q;
  logic [31:0]       loc_start_q;
  logic [31:0]       loc_end_q;
  logic [31:0]       hit_count_q;

  logic              req_valid;
  logic              data_ready;
  logic              req_fire;
  logic              rsp_fire;
  logic [31:0]       word_nt_base;

  // Buffer must be empty and nothing in flight, so a response always finds room.
  assign req_valid    = (state_q != S_IDLE) && (req_idx_q < num_q) && !outstanding_q && !buf_full_q;
  assign data_ready   = !buf_full_q;
  assign req_fire     = req_valid && bus.rd_req_ready;
  assign rsp_fire     = bus.rd_data_valid && data_ready;
  assign word_nt_base = cur_idx_q * NT_PER_WORD;

  assign bus.rd_req_valid  = req_valid;
  assign bus.rd_req_addr   = base_q + ADDR_W'(req_idx_q) * STRIDE;
  assign bus.rd_data_ready = data_ready;
  // Combinational so the detector freezes on the very cycle its comparators fire;
  // the last window position never shifts because there is nothing after it.
  assign bus.shift         = (state_q == S_SCAN) && !bus.hit && (pos_q != LAST_POS);

  assign bus.dataBase      = data_base_q;
  assign bus.dataBaseValid = dbv_q;
  assign bus.load          = load_q;
  assign bus.stop          = stop_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.locationStart = loc_start_q;
  assign bus.locationEnd   = loc_end_q;
  assign bus.hit_count     = hit_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      num_q         <= '0;
      req_idx_q     <= '0;
      cur_idx_q     <= '0;
      pos_q         <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      outstanding_q <= 1'b0;
      data_base_q   <= '0;
      dbv_q         <= 1'b0;
      load_q        <= 1'b0;
      stop_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      loc_start_q   <= '0;
      loc_end_q     <= '0;
      hit_count_q   <= '0;
    end else begin
      load_q <= 1'b0;
      stop_q <= 1'b0;
      done_q <= 1'b0;

      if (req_fire) begin
        outstanding_q <= 1'b1;
        req_idx_q     <= req_idx_q + 32'd1;
      end
      if (rsp_fire) begin
        buf_q         <= bus.rd_data;
        buf_full_q    <= 1'b1;
        outstanding_q <= 1'b0;
      end

      // Pulse/level outputs are set on the edge entering their state so they
      // are valid for exactly the cycles spent in that state.
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            base_q      <= bus.db_base_addr;
            num_q       <= bus.db_num_words;
            req_idx_q   <= '0;
            cur_idx_q   <= '0;
            hit_count_q <= '0;
            busy_q      <= 1'b1;
            if (bus.db_num_words == 32'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAITW;
            end
          end
        end
        S_WAITW: begin
          if (buf_full_q) begin
            state_q     <= S_LOAD;
            data_base_q <= buf_q;
            load_q      <= 1'b1;
            dbv_q       <= 1'b1;
          end
        end
        S_LOAD: begin
          buf_full_q <= 1'b0;
          pos_q      <= '0;
          state_q    <= S_SCAN;
        end
        S_SCAN: begin
          if (bus.hit) begin
            hit_count_q <= hit_count_q + 32'd1;
            loc_start_q <= word_nt_base + 32'(pos_q);
            loc_end_q   <= word_nt_base + NT_PER_WORD - 32'd1;
            dbv_q       <= 1'b0;
            state_q     <= S_HOLD;
          end else if (pos_q == LAST_POS) begin
            dbv_q   <= 1'b0;
            state_q <= S_NEXT;
          end else begin
            pos_q <= pos_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (bus.ext_done) begin
            stop_q  <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (pos_q < LAST_POS) begin
            pos_q   <= pos_q + 8'd1;
            dbv_q   <= 1'b1;
            state_q <= S_SCAN;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (cur_idx_q == num_q - 32'd1) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cur_idx_q <= cur_idx_q + 32'd1;
            state_q   <= S_WAITW;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hit_db_feeder.sv
// tb/tb_hit_db_feeder.sv - self-checking bench for hit_db_feeder
module tb_hit_db_feeder;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 32;
  localparam int LAST   = 245;

  typedef struct {
    int word;
    int pos;
  } hit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hit_t hit_q[$];
  int   load_cyc[$];
  int   first_load;
  int   n_acc;
  int   done_cyc;
  bit   overlap;

  hit_db_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  hit_db_feeder #(.DATA_W(DATA_W), .WMER_NT(11), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_data(input logic [31:0] a);
    return {16{a ^ 32'h5A5A_C3C3}};
  endfunction

  task automatic idle_inputs();
    bus.start         = 1'b0;
    bus.db_base_addr  = '0;
    bus.db_num_words  = '0;
    bus.rd_req_ready  = 1'b0;
    bus.rd_data       = '0;
    bus.rd_data_valid = 1'b0;
    bus.hit           = 1'b0;
    bus.ext_done      = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.load !== 1'b0 || bus.shift !== 1'b0 ||
        bus.stop !== 1'b0 || bus.dataBaseValid !== 1'b0 || bus.rd_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: busy=%b done=%b load=%b shift=%b stop=%b dbv=%b rqv=%b, want all 0",
               tag, bus.busy, bus.done, bus.load, bus.shift, bus.stop, bus.dataBaseValid, bus.rd_req_valid);
    end
    checks++;
    if (bus.rd_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_rd_data_ready: got %b want 1", tag, bus.rd_data_ready);
    end
    checks++;
    if (bus.hit_count !== 32'd0 || bus.locationStart !== 32'd0 || bus.locationEnd !== 32'd0) begin
      errors++;
      $display("FAIL %s_counters: hit_count=%0d locS=%0d locE=%0d want 0", tag,
               bus.hit_count, bus.locationStart, bus.locationEnd);
    end
    checks++;
    if (bus.dataBase !== '0) begin
      errors++;
      $display("FAIL %s_dataBase: got nonzero want 0", tag);
    end
  endtask

  // Drives one complete scan cycle by cycle: DDR responder, detector model and
  // extender model, comparing every observed event with what hit_q predicts.
  task automatic run_scan(input int num, input logic [31:0] base, input int lat, input int extd,
                          input bit rnd_ready, input int stray, input bit abort);
    hit_t        det_q[$];
    hit_t        exp_q[$];
    logic [31:0] cur_addr = '0;
    logic [31:0] eaddr;
    int          n = 0, loads = 0, shifts = 0, stops = 0, exp_shifts;
    int          due = -1, ext_due = -1, stop_due = -1, hold_at = -1, wm = 0, pm = 0;
    bit          pend = 0, hold = 0, fin = 0, hit_now, dv_now, ext_now;
    det_q = hit_q;
    exp_q = hit_q;
    exp_shifts = LAST * num;
    foreach (hit_q[i]) if (hit_q[i].pos < LAST) exp_shifts--;
    first_load = -1;
    n_acc      = 0;
    done_cyc   = -1;
    overlap    = 0;
    load_cyc.delete();
    while (!fin && n < 20000) begin
      @(negedge clk);
      bus.start         = (n == 0) || (n == stray);
      bus.db_base_addr  = (n == 0) ? base : 32'hDEAD_0000;
      bus.db_num_words  = (n == 0) ? 32'(num) : 32'd9;
      bus.rd_req_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      dv_now            = pend && (n == due);
      bus.rd_data_valid = dv_now;
      bus.rd_data       = dv_now ? word_data(cur_addr) : '0;
      ext_now           = hold && (n == ext_due);
      bus.ext_done      = ext_now;
      hit_now = bus.dataBaseValid && !bus.load && det_q.size() > 0 &&
                det_q[0].word == wm && det_q[0].pos == pm;
      bus.hit = hit_now;
      #1;
      if (bus.rd_req_valid && bus.rd_req_ready) begin
        eaddr = base + 32'(n_acc) * 32'd64;
        checks++;
        if (pend || n_acc >= num || bus.rd_req_addr !== eaddr) begin
          errors++;
          $display("FAIL rd_req: addr %h want %h (outstanding=%0d issued=%0d of %0d)",
                   bus.rd_req_addr, eaddr, pend, n_acc, num);
        end
        n_acc++;
        pend     = 1;
        due      = n + lat;
        cur_addr = eaddr;
        if (bus.dataBaseValid) overlap = 1;
      end
      if (dv_now) begin
        checks++;
        if (bus.rd_data_ready !== 1'b1) begin
          errors++;
          $display("FAIL rd_data_ready: got %b want 1 with response pending", bus.rd_data_ready);
        end
        if (due == n) pend = 0;
      end
      if (hit_now) begin
        checks++;
        if (bus.shift !== 1'b0) begin
          errors++;
          $display("FAIL shift_on_hit: got %b want 0 at word %0d pos %0d", bus.shift, wm, pm);
        end
        hold    = 1;
        hold_at = n;
        ext_due = n + extd;
        void'(det_q.pop_front());
      end
      if (ext_now) begin
        hold     = 0;
        stop_due = n + 1;
      end
      if (bus.load) begin
        checks++;
        if (bus.dataBase !== word_data(base + 32'(loads) * 32'd64)) begin
          errors++;
          $display("FAIL load_data: word %0d got %h want %h", loads, bus.dataBase[31:0],
                   word_data(base + 32'(loads) * 32'd64) & 32'hFFFF_FFFF);
        end
        if (first_load < 0) first_load = n;
        load_cyc.push_back(n);
        wm = loads;
        loads++;
        pm = 0;
      end
      if (bus.shift) begin
        shifts++;
        pm++;
      end
      if (bus.stop) begin
        checks++;
        if (n != stop_due || exp_q.size() == 0) begin
          errors++;
          $display("FAIL stop_timing: stop at cycle %0d want %0d", n, stop_due);
        end else begin
          checks++;
          if (bus.locationStart !== 32'(exp_q[0].word * 256 + exp_q[0].pos) ||
              bus.locationEnd !== 32'(exp_q[0].word * 256 + 255)) begin
            errors++;
            $display("FAIL location: got %0d/%0d want %0d/%0d", bus.locationStart, bus.locationEnd,
                     exp_q[0].word * 256 + exp_q[0].pos, exp_q[0].word * 256 + 255);
          end
          void'(exp_q.pop_front());
        end
        stops++;
        pm++;
      end
      if (bus.done) begin
        done_cyc = n;
        fin      = 1;
      end
      if (abort && hold && n == hold_at + 2) fin = 1;
      n++;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: no done after %0d cycles", n);
      return;
    end
    if (abort) return;
    checks++;
    if (loads != num || n_acc != num) begin
      errors++;
      $display("FAIL word_counts: loads=%0d reqs=%0d want %0d", loads, n_acc, num);
    end
    checks++;
    if (shifts != exp_shifts) begin
      errors++;
      $display("FAIL shift_count: got %0d want %0d", shifts, exp_shifts);
    end
    checks++;
    if (stops != hit_q.size() || bus.hit_count !== 32'(hit_q.size())) begin
      errors++;
      $display("FAIL hit_count: stops=%0d hit_count=%0d want %0d", stops, bus.hit_count, hit_q.size());
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("reset");
  endtask

  task automatic test_empty();
    hit_q.delete();
    run_scan(0, 32'h2000, 3, 1, 0, -1, 0);
    checks++;
    if (done_cyc != 1 || n_acc != 0) begin
      errors++;
      $display("FAIL empty_scan: done at %0d reqs %0d want 1 / 0", done_cyc, n_acc);
    end
  endtask

  task automatic test_single_nohit();
    hit_q.delete();
    run_scan(1, 32'h0, 4, 1, 0, -1, 0);
    checks++;
    if (first_load != 3 + 4) begin
      errors++;
      $display("FAIL first_load_latency: got %0d want %0d", first_load, 3 + 4);
    end
  endtask

  task automatic test_single_hit();
    hit_q.delete();
    hit_q.push_back('{0, 10});
    run_scan(1, 32'h40, 4, 5, 0, -1, 0);
  endtask

  task automatic test_multi_word();
    hit_q.delete();
    hit_q.push_back('{2, 0});
    run_scan(3, 32'h1000, 20, 3, 0, 50, 0);
    checks++;
    if (!overlap) begin
      errors++;
      $display("FAIL prefetch_overlap: got 0 want 1");
    end
    checks++;
    if (first_load != 23 || load_cyc.size() < 2 || load_cyc[1] - load_cyc[0] != 249) begin
      errors++;
      $display("FAIL word_gap: first load %0d want 23, gap %0d want 249", first_load,
               (load_cyc.size() < 2) ? -1 : load_cyc[1] - load_cyc[0]);
    end
  endtask

  task automatic test_last_pos();
    hit_q.delete();
    hit_q.push_back('{0, 244});
    hit_q.push_back('{0, 245});
    hit_q.push_back('{1, 100});
    run_scan(2, 32'h4000, 2, 2, 0, -1, 0);
  endtask

  task automatic test_random();
    int num;
    int p;
    for (int k = 0; k < 6; k++) begin
      num = int'($urandom_range(1, 4));
      hit_q.delete();
      for (int w = 0; w < num; w++) begin
        p = -1;
        for (int j = 0; j < 4; j++) begin
          p = p + 1 + int'($urandom_range(0, 90));
          if (p > LAST) break;
          if ($urandom_range(0, 3) != 0) hit_q.push_back('{w, p});
        end
      end
      run_scan(num, $urandom & 32'hFFFF_FFC0, int'($urandom_range(1, 30)),
               int'($urandom_range(1, 8)), 1, 40, 0);
    end
  endtask

  task automatic test_reset_in_hold();
    hit_q.delete();
    hit_q.push_back('{0, 5});
    run_scan(1, 32'h8000, 3, 100, 0, -1, 1);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("rst_in_hold");
    hit_q.delete();
    hit_q.push_back('{0, 7});
    run_scan(1, 32'h8000, 3, 2, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single_nohit();
    test_single_hit();
    test_multi_word();
    test_last_pos();
    test_random();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
